ram_access_master: RTL and testbench
====================================

Name: ram_access_master

Overview:
- Initiator-side controller for the 8-bit single-port data RAM. The RAM writes on the falling clock edge when WE is high and returns read data combinationally from the address.
- Accepts single LOAD/STORE requests and block FILL/COPY requests from the CPU core over a valid/ready handshake.
- Sequences the RAM's address, write-enable, chip-select and write-data lines, and returns read data to the requester.
- Sits between the CPU execute stage and the RAM instance.

Parameters:
ADDR_W, 8, width of every address (RAM depth = 2**ADDR_W)
DATA_W, 8, data width
LEN_W, 8, width of the block-length field

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_op  in  2  00 LOAD, 01 STORE, 10 FILL, 11 COPY
req_addr  in  ADDR_W  target / destination address
req_src  in  ADDR_W  source address (COPY only)
req_data  in  DATA_W  store/fill value
req_len  in  LEN_W  byte count (FILL/COPY)
rsp_valid  out  1  one-cycle pulse: rsp_data valid (LOAD only)
rsp_data  out  DATA_W  loaded byte; held until next LOAD
done  out  1  one-cycle pulse: request complete
busy  out  1  high from accept until last access cycle inclusive
mem_cs  out  1  RAM chip-select
mem_we  out  1  RAM write-enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data (combinational from mem_addr)

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst). While rst=1, all outputs are 0 except req_ready (also 0) and rsp_data (0). After rst deasserts, the FSM is in IDLE.
- All mem_* outputs are registered. mem_cs=1 exactly in RD/WR cycles; mem_we=1 exactly in WR cycles. When mem_cs=0, mem_addr and mem_wdata hold their last values.
- FSM states: IDLE, RD, WR.
- IDLE: req_ready=1.
  - Accept on rising edge with req_valid&&req_ready; latch all req_* fields.
  - LOAD -> RD. STORE -> WR. FILL -> WR if len!=0. COPY -> RD if len!=0.
  - FILL/COPY with len=0: no RAM access; stay IDLE; done pulses the next cycle.
- RD cycle:
  - mem_addr = current source address (LOAD: req_addr).
  - mem_rdata is sampled at the closing rising edge.
  - LOAD: rsp_data <= sample, then -> IDLE.
  - COPY: byte register <= sample, then -> WR.
- WR cycle:
  - mem_addr = current destination address; mem_wdata = req_data (STORE/FILL) or the byte register (COPY).
  - The RAM commits at the mid-cycle falling edge.
  - STORE -> IDLE.
  - FILL: decrement remaining count and increment destination; stay WR until count reaches 0, then -> IDLE.
  - COPY: decrement count, increment src and dst; -> RD if count != 0, else -> IDLE.
- Completion: done (and rsp_valid for LOAD) is high for exactly the first IDLE cycle after the last access. req_ready is also high in that cycle, so back-to-back requests are allowed.
- Latency from accept edge to done:
  - LOAD/STORE: 2 cycles.
  - FILL: len+1 cycles.
  - COPY: 2*len+1 cycles.
- Addresses wrap modulo 2**ADDR_W (e.g. FILL at 0xFE, len 3 writes 0xFE, 0xFF, 0x00).
- COPY is strictly forward, one byte at a time. Overlap with dst=src+1 therefore replicates the first byte (defined behaviour).
- req_valid while busy is ignored; there is no queuing.
- Reset mid-operation: the access is aborted immediately. mem_we drops asynchronously, no done is issued, and partially written bytes remain in the RAM.
- Unknown or illegal states return to IDLE.

Optional Feature:
- Macro RAM_MASTER_VERIFY_EN.
- Defined:
  - Adds output port err (1 bit) and state VF.
  - Every WR cycle is followed by one VF cycle: mem_cs=1, mem_we=0, same mem_addr. mem_rdata is compared with the written byte.
  - A mismatch sets err. err is sticky until the next accept; it is valid when done pulses.
  - Latency adds 1 cycle per written byte.
- Not defined: no err port, no VF state, timings exactly as above.

Test Plan:
- Reset, then STORE addr 0x10 data 0xA5 -> one WR cycle with mem_we=1, mem_addr=0x10, mem_wdata=0xA5; done 2 cycles after accept. Then LOAD 0x10 -> rsp_valid and done together, rsp_data=0xA5, 2 cycles after accept.
- FILL addr 0xFE len 3 data 0x3C -> writes to 0xFE, 0xFF, 0x00 on consecutive cycles; done 4 cycles after accept; 0xFD and 0x01 unchanged.
- Preload 0x20..0x23 = 11,22,33,44; COPY src 0x20 dst 0x40 len 4 -> alternating RD/WR cycles; 0x40..0x43 = 11,22,33,44; done 9 cycles after accept.
- COPY src 0x20 dst 0x21 len 3 with 0x20=0x77 -> 0x21..0x23 all 0x77.
- FILL len 0 -> mem_cs never asserted; done 1 cycle after accept. A req_valid held during a FILL len 5 -> req_ready=0 and the request is not taken until done.
- rst asserted during the 3rd WR of FILL len 8 at 0x80 -> mem_we=0 immediately; only 0x80, 0x81 (and 0x82 if past the falling edge) are written; no done pulse. With RAM_MASTER_VERIFY_EN, a RAM model forcing bit 0 low: STORE 0x01 -> err=1 at done.

Source files
------------

// File: rtl/ram_access_master.sv
// ram_access_master: CPU-side sequencer for LOAD/STORE/FILL/COPY accesses to a single-port RAM
// with registered mem_* outputs; `RAM_MASTER_VERIFY_EN adds a read-back VF cycle after every write and an err output.
module ram_access_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_src,
  input  logic [DATA_W-1:0] req_data,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              done,
  output logic              busy,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef RAM_MASTER_VERIFY_EN
  ,
  output logic              err
`endif
);
  localparam logic [1:0] OP_LOAD = 2'b00, OP_STORE = 2'b01, OP_FILL = 2'b10, OP_COPY = 2'b11;
`ifdef RAM_MASTER_VERIFY_EN
  typedef enum logic [1:0] {IDLE, RD, WR, VF} state_t;
`else
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
`endif
  state_t state, nxt_state, wr_next;
  logic [1:0] op_q, nxt_op;
  logic [ADDR_W-1:0] src_q, dst_q, nxt_src, nxt_dst, nxt_addr;
  logic [DATA_W-1:0] data_q, byte_q, nxt_data, nxt_byte, nxt_wdata, nxt_rsp;
  logic [LEN_W-1:0] cnt_q, nxt_cnt;
  logic accept, wr_end, nxt_done, nxt_rsp_valid;
  assign req_ready = (state == IDLE) && !rst;
  assign busy = (state != IDLE);
  assign accept = req_ready && req_valid;
  // Pointers and count advance once per written byte, after its read-back when verifying
`ifdef RAM_MASTER_VERIFY_EN
  assign wr_end = (state == VF);
`else
  assign wr_end = (state == WR);
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt_state;
  always_comb begin
    wr_next = (op_q == OP_STORE || cnt_q == LEN_W'(1)) ? IDLE : (op_q == OP_COPY) ? RD : WR;
    nxt_state = IDLE;
    case (state)
      IDLE: nxt_state = !accept ? IDLE : (req_op == OP_LOAD) ? RD : (req_op == OP_STORE) ? WR :
                        (req_len == '0) ? IDLE : (req_op == OP_FILL) ? WR : RD;
      RD: nxt_state = (op_q == OP_LOAD) ? IDLE : WR;
`ifdef RAM_MASTER_VERIFY_EN
      WR: nxt_state = VF;
      VF: nxt_state = wr_next;
`else
      WR: nxt_state = wr_next;
`endif
      default: nxt_state = IDLE;
    endcase
  end
  always_comb begin
    nxt_op = accept ? req_op : op_q;
    nxt_src = accept ? ((req_op == OP_LOAD) ? req_addr : req_src) :
              (wr_end && op_q == OP_COPY) ? src_q + ADDR_W'(1) : src_q;
    nxt_dst = accept ? req_addr : wr_end ? dst_q + ADDR_W'(1) : dst_q;
    nxt_cnt = accept ? req_len : (wr_end && cnt_q != '0) ? cnt_q - LEN_W'(1) : cnt_q;
    nxt_data = accept ? req_data : data_q;
    nxt_byte = (state == RD) ? mem_rdata : byte_q;
    nxt_addr = (nxt_state == RD) ? nxt_src : (nxt_state == WR) ? nxt_dst : mem_addr;
    nxt_wdata = (nxt_state != WR) ? mem_wdata : (nxt_op == OP_COPY) ? nxt_byte : nxt_data;
    nxt_rsp_valid = (state == RD) && (op_q == OP_LOAD);
    nxt_rsp = nxt_rsp_valid ? mem_rdata : rsp_data;
    nxt_done = (state != IDLE && nxt_state == IDLE) || (accept && req_op[1] && req_len == '0);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_q <= '0;
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      byte_q <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      done <= 1'b0;
      mem_cs <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      op_q <= nxt_op;
      src_q <= nxt_src;
      dst_q <= nxt_dst;
      cnt_q <= nxt_cnt;
      data_q <= nxt_data;
      byte_q <= nxt_byte;
      rsp_valid <= nxt_rsp_valid;
      rsp_data <= nxt_rsp;
      done <= nxt_done;
      mem_cs <= (nxt_state != IDLE);
      mem_we <= (nxt_state == WR);
      mem_addr <= nxt_addr;
      mem_wdata <= nxt_wdata;
    end
`ifdef RAM_MASTER_VERIFY_EN
  // mem_wdata still holds the byte just written while in VF
  always_ff @(posedge clk or posedge rst)
    if (rst) err <= 1'b0;
    else err <= accept ? 1'b0 : (state == VF && mem_rdata != mem_wdata) ? 1'b1 : err;
`endif
endmodule

// File: tb/tb_ram_access_master.sv
// tb_ram_access_master: directed self-checking bench for ram_access_master with a falling-edge-write RAM model.
module tb_ram_access_master;
  logic clk = 1'b0, rst = 1'b0, req_valid = 1'b0;
  logic req_ready, rsp_valid, done, busy, mem_cs, mem_we;
  logic [1:0] req_op = 2'b00;
  logic [7:0] req_addr = '0, req_src = '0, req_data = '0, req_len = '0;
  logic [7:0] rsp_data, mem_addr, mem_wdata, mem_rdata;
  logic [7:0] ram [256];
`ifdef RAM_MASTER_VERIFY_EN
  logic err;
`endif
  int n_cmp = 0, n_fail = 0;

  ram_access_master dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_src(req_src), .req_data(req_data), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .done(done), .busy(busy),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef RAM_MASTER_VERIFY_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;
  assign mem_rdata = ram[mem_addr];
  always @(negedge clk) if (mem_we) ram[mem_addr] = mem_wdata;

  task automatic drive(input logic [1:0] op, input logic [7:0] addr, src, data, len);
    req_op = op; req_addr = addr; req_src = src; req_data = data; req_len = len; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 600) begin @(posedge clk); #1; cyc++; end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%0h exp=0", req_ready); end
    n_cmp++; if ({busy, done, rsp_valid, mem_cs, mem_we} !== 5'b0) begin n_fail++; $display("FAIL rst_flags got=%b exp=00000", {busy, done, rsp_valid, mem_cs, mem_we}); end
    n_cmp++; if ({rsp_data, mem_addr, mem_wdata} !== 24'h0) begin n_fail++; $display("FAIL rst_data got=%h exp=000000", {rsp_data, mem_addr, mem_wdata}); end
    @(posedge clk); #1 rst = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready got=%0h exp=1", req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_store_load;
    int c;
    drive(2'b01, 8'h10, 8'h00, 8'hA5, 8'h00);
    n_cmp++; if ({mem_cs, mem_we, busy, req_ready} !== 4'b1110) begin n_fail++; $display("FAIL store_ctl got=%b exp=1110", {mem_cs, mem_we, busy, req_ready}); end
    n_cmp++; if ({mem_addr, mem_wdata} !== 16'h10A5) begin n_fail++; $display("FAIL store_bus got=%h exp=10a5", {mem_addr, mem_wdata}); end
    wait_done(c);
    n_cmp++; if (c !== 2) begin n_fail++; $display("FAIL store_lat got=%0d exp=2", c); end
    n_cmp++; if ({rsp_valid, busy, mem_cs, req_ready} !== 4'b0001) begin n_fail++; $display("FAIL store_done got=%b exp=0001", {rsp_valid, busy, mem_cs, req_ready}); end
    n_cmp++; if (ram[8'h10] !== 8'hA5) begin n_fail++; $display("FAIL store_ram got=%h exp=a5", ram[8'h10]); end
    drive(2'b00, 8'h10, 8'h00, 8'h00, 8'h00);
    n_cmp++; if ({mem_cs, mem_we, busy, mem_addr} !== {3'b101, 8'h10}) begin n_fail++; $display("FAIL load_rd got=%h exp=%h", {mem_cs, mem_we, busy, mem_addr}, {3'b101, 8'h10}); end
    wait_done(c);
    n_cmp++; if (c !== 2) begin n_fail++; $display("FAIL load_lat got=%0d exp=2", c); end
    n_cmp++; if ({rsp_valid, rsp_data} !== {1'b1, 8'hA5}) begin n_fail++; $display("FAIL load_rsp got=%h exp=1a5", {rsp_valid, rsp_data}); end
    @(posedge clk); #1;
    n_cmp++; if ({rsp_valid, done, rsp_data, mem_cs, mem_addr} !== {2'b00, 8'hA5, 1'b0, 8'h10}) begin n_fail++; $display("FAIL load_hold got=%h exp=%h", {rsp_valid, done, rsp_data, mem_cs, mem_addr}, {2'b00, 8'hA5, 1'b0, 8'h10}); end
  endtask

  task automatic test_fill_wrap;
    logic [7:0] a;
    ram[8'hFD] = 8'h55; ram[8'h01] = 8'h66;
    ram[8'hFE] = 8'h00; ram[8'hFF] = 8'h00; ram[8'h00] = 8'h00;
    drive(2'b10, 8'hFE, 8'h00, 8'h3C, 8'd3);
    for (int i = 0; i < 3; i++) begin
      a = 8'(8'hFE + i);
      n_cmp++; if ({mem_cs, mem_we, done, mem_addr, mem_wdata} !== {3'b110, a, 8'h3C}) begin n_fail++; $display("FAIL fill_wr%0d got=%h exp=%h", i, {mem_cs, mem_we, done, mem_addr, mem_wdata}, {3'b110, a, 8'h3C}); end
      @(posedge clk); #1;
    end
    n_cmp++; if ({done, mem_cs} !== 2'b10) begin n_fail++; $display("FAIL fill_done got=%b exp=10", {done, mem_cs}); end
    n_cmp++; if ({ram[8'hFE], ram[8'hFF], ram[8'h00]} !== 24'h3C3C3C) begin n_fail++; $display("FAIL fill_ram got=%h exp=3c3c3c", {ram[8'hFE], ram[8'hFF], ram[8'h00]}); end
    n_cmp++; if ({ram[8'hFD], ram[8'h01]} !== 16'h5566) begin n_fail++; $display("FAIL fill_edges got=%h exp=5566", {ram[8'hFD], ram[8'h01]}); end
  endtask

  task automatic test_copy;
    logic [7:0] s, d, v;
    for (int i = 0; i < 4; i++) begin ram[8'h20 + i] = 8'(8'h11 * (i + 1)); ram[8'h40 + i] = 8'h00; end
    drive(2'b11, 8'h40, 8'h20, 8'h00, 8'd4);
    for (int i = 0; i < 4; i++) begin
      s = 8'(8'h20 + i); d = 8'(8'h40 + i); v = 8'(8'h11 * (i + 1));
      n_cmp++; if ({mem_cs, mem_we, mem_addr} !== {2'b10, s}) begin n_fail++; $display("FAIL copy_rd%0d got=%h exp=%h", i, {mem_cs, mem_we, mem_addr}, {2'b10, s}); end
      @(posedge clk); #1;
      n_cmp++; if ({mem_cs, mem_we, mem_addr, mem_wdata} !== {2'b11, d, v}) begin n_fail++; $display("FAIL copy_wr%0d got=%h exp=%h", i, {mem_cs, mem_we, mem_addr, mem_wdata}, {2'b11, d, v}); end
      @(posedge clk); #1;
    end
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL copy_lat9 got=%0h exp=1", done); end
    n_cmp++; if ({ram[8'h40], ram[8'h41], ram[8'h42], ram[8'h43]} !== 32'h11223344) begin n_fail++; $display("FAIL copy_ram got=%h exp=11223344", {ram[8'h40], ram[8'h41], ram[8'h42], ram[8'h43]}); end
  endtask

  task automatic test_copy_overlap;
    int c;
    ram[8'h20] = 8'h77; ram[8'h21] = 8'h01; ram[8'h22] = 8'h02; ram[8'h23] = 8'h03;
    drive(2'b11, 8'h21, 8'h20, 8'h00, 8'd3);
    wait_done(c);
    n_cmp++; if (c !== 7) begin n_fail++; $display("FAIL overlap_lat got=%0d exp=7", c); end
    n_cmp++; if ({ram[8'h21], ram[8'h22], ram[8'h23]} !== 24'h777777) begin n_fail++; $display("FAIL overlap_ram got=%h exp=777777", {ram[8'h21], ram[8'h22], ram[8'h23]}); end
  endtask

  task automatic test_len_zero;
    ram[8'h50] = 8'h5A;
    drive(2'b10, 8'h50, 8'h00, 8'hAA, 8'd0);
    n_cmp++; if ({done, mem_cs, busy, req_ready} !== 4'b1001) begin n_fail++; $display("FAIL fill0 got=%b exp=1001", {done, mem_cs, busy, req_ready}); end
    drive(2'b11, 8'h50, 8'h20, 8'h00, 8'd0);
    n_cmp++; if ({done, mem_cs, busy} !== 3'b100) begin n_fail++; $display("FAIL copy0 got=%b exp=100", {done, mem_cs, busy}); end
    @(posedge clk); #1;
    n_cmp++; if ({done, ram[8'h50]} !== {1'b0, 8'h5A}) begin n_fail++; $display("FAIL len0_after got=%h exp=05a", {done, ram[8'h50]}); end
  endtask

  task automatic test_back_to_back;
    int c;
    logic [7:0] a;
    for (int i = 0; i < 6; i++) ram[8'h60 + i] = 8'h00;
    ram[8'h70] = 8'h00;
    req_op = 2'b10; req_addr = 8'h60; req_src = 8'h00; req_data = 8'h99; req_len = 8'd5; req_valid = 1'b1;
    @(posedge clk); #1;
    req_op = 2'b01; req_addr = 8'h70; req_data = 8'hEE; req_len = 8'd0;
    c = 1;
    while (done !== 1'b1 && c < 20) begin
      a = 8'(8'h60 + c - 1);
      n_cmp++; if ({req_ready, mem_we, mem_addr} !== {2'b01, a}) begin n_fail++; $display("FAIL busy_c%0d got=%h exp=%h", c, {req_ready, mem_we, mem_addr}, {2'b01, a}); end
      @(posedge clk); #1; c++;
    end
    n_cmp++; if ({c, req_ready} !== {32'd6, 1'b1}) begin n_fail++; $display("FAIL busy_lat got=%0d/%0d exp=6/1", c, req_ready); end
    @(posedge clk); #1 req_valid = 1'b0;
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h70, 8'hEE}) begin n_fail++; $display("FAIL b2b_store got=%h exp=170ee", {mem_we, mem_addr, mem_wdata}); end
    wait_done(c);
    n_cmp++; if (c !== 2) begin n_fail++; $display("FAIL b2b_lat got=%0d exp=2", c); end
    n_cmp++; if ({ram[8'h60], ram[8'h64], ram[8'h65], ram[8'h70]} !== 32'h999900EE) begin n_fail++; $display("FAIL b2b_ram got=%h exp=999900ee", {ram[8'h60], ram[8'h64], ram[8'h65], ram[8'h70]}); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) ram[8'h80 + i] = 8'h00;
    drive(2'b10, 8'h80, 8'h00, 8'hC3, 8'd8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if ({mem_we, mem_addr} !== {1'b1, 8'h82}) begin n_fail++; $display("FAIL mid_wr3 got=%h exp=182", {mem_we, mem_addr}); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({mem_we, mem_cs, busy, req_ready, done, rsp_data} !== {5'b0, 8'h00}) begin n_fail++; $display("FAIL mid_abort got=%h exp=0", {mem_we, mem_cs, busy, req_ready, done, rsp_data}); end
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({done, mem_cs} !== 2'b00) begin n_fail++; $display("FAIL mid_nodone%0d got=%b exp=00", i, {done, mem_cs}); end
      @(posedge clk); #1;
    end
    n_cmp++; if ({ram[8'h80], ram[8'h81], ram[8'h82], ram[8'h83]} !== 32'hC3C30000) begin n_fail++; $display("FAIL mid_ram got=%h exp=c3c30000", {ram[8'h80], ram[8'h81], ram[8'h82], ram[8'h83]}); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    test_reset;
    test_store_load;
    test_fill_wrap;
    test_copy;
    test_copy_overlap;
    test_len_zero;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end
endmodule
